trigger_cmd_issuer: RTL and testbench



---
 rtl/trigger_pkg.sv | 26 ++
 rtl/trigger_cmd_issuer_if.sv | 24 ++
 rtl/cmd_timeout_ctr.sv | 26 ++
 rtl/trigger_cmd_issuer.sv | 152 +++++++++++++++
 tb/tb_trigger_cmd_issuer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/trigger_pkg.sv
// Shared trigger-bus definitions: opcodes, status bytes and the issuer FSM states.
// Used by the trigger system, the host deframer and the command issuer.
package trigger_pkg;

  localparam logic [7:0] CMD_TRIG_RUN    = 8'd0;
  localparam logic [7:0] CMD_TRIG_HALT   = 8'd1;
  localparam logic [7:0] CMD_TRIG_CFG_LO = 8'd2;
  localparam logic [7:0] CMD_TRIG_CFG_HI = 8'd9;

  localparam logic [7:0] ACK_BASE  = 8'hA0;
  localparam logic [7:0] NAK_BUSY  = 8'hEB;
  localparam logic [7:0] NAK_BADOP = 8'hEE;
  localparam logic [7:0] FIRED     = 8'hF1;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_DECODE,
    ST_ISSUE,
    ST_RESP
  } issuer_state_t;

  function automatic logic [7:0] ack_byte(input logic [7:0] op);
    return ACK_BASE | {4'h0, op[3:0]};
  endfunction

endpackage

// File: rtl/trigger_cmd_issuer_if.sv
// Host byte streams plus the trigger configuration bus seen by the command issuer.
interface trigger_cmd_issuer_if #(parameter int NSTAGES = 4);
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic [7:0]         command;
  logic [23:0]        config_in;
  logic [NSTAGES-1:0] we;
  logic               trig;
  logic               running;

  modport master (
    input  rx_data, rx_valid, tx_ready, trig,
    output rx_ready, tx_data, tx_valid, command, config_in, we, running
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, trig,
    input  rx_ready, tx_data, tx_valid, command, config_in, we, running
  );
endinterface

// File: rtl/cmd_timeout_ctr.sv
// Inter-byte timeout: counts idle cycles inside a partial packet, flags expiry at TIMEOUT-1.
module cmd_timeout_ctr #(
  parameter int TIMEOUT = 1000000
) (
  input  logic inclk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);
  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  assign expired = run && (cnt == LAST);

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr || expired)
      cnt <= '0;
    else if (run)
      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/trigger_cmd_issuer.sv
// Decodes 5-byte host packets into trigger bus cycles and answers with ACK/NAK/FIRED bytes.
module trigger_cmd_issuer
  import trigger_pkg::*;
#(
  parameter int TIMEOUT = 1000000,
  parameter int NSTAGES = 4
) (
  input logic                  inclk,
  input logic                  rst_n,
  trigger_cmd_issuer_if.master bus
);
  issuer_state_t      state, state_nxt;
  logic [2:0]         byte_cnt;
  logic [7:0]         opcode;
  logic [23:0]        cfg_buf;
  logic [NSTAGES-1:0] mask_buf;
  logic [7:0]         idle_cmd;
  logic               trig_q, fire_pending, fired_run;
  logic               resp_pend, tx_is_ack;
  logic [7:0]         resp_byte;
  logic               rx_fire, tx_done, to_expired, op_is_cfg, fire_edge;

  assign bus.rx_ready = (state == ST_COLLECT);
  assign rx_fire      = bus.rx_valid && bus.rx_ready;
  assign tx_done      = bus.tx_valid && bus.tx_ready;
  assign op_is_cfg    = (opcode >= CMD_TRIG_CFG_LO) && (opcode <= CMD_TRIG_CFG_HI);
  // One FIRED byte per run: fired_run blocks re-arming until the next RUN.
  assign fire_edge    = bus.trig && !trig_q && bus.running && !fired_run;

  cmd_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .inclk   (inclk),
    .rst_n   (rst_n),
    .clr     (rx_fire),
    .run     (byte_cnt != 3'd0),
    .expired (to_expired)
  );

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) state <= ST_COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_COLLECT: if (rx_fire && byte_cnt == 3'd4) state_nxt = ST_DECODE;
      ST_DECODE:  state_nxt = (op_is_cfg && !bus.running) ? ST_ISSUE : ST_RESP;
      ST_ISSUE:   state_nxt = ST_RESP;
      ST_RESP:    if (tx_done && tx_is_ack) state_nxt = ST_COLLECT;
      default:    state_nxt = ST_COLLECT;
    endcase
  end

  // Packet payload capture
  always_ff @(posedge inclk) begin
    if (rx_fire) begin
      case (byte_cnt)
        3'd0:    opcode          <= bus.rx_data;
        3'd1:    cfg_buf[23:16]  <= bus.rx_data;
        3'd2:    cfg_buf[15:8]   <= bus.rx_data;
        3'd3:    cfg_buf[7:0]    <= bus.rx_data;
        default: mask_buf        <= bus.rx_data[NSTAGES-1:0];
      endcase
    end
  end

  // Control, bus outputs and response stream
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt      <= 3'd0;
      idle_cmd      <= CMD_TRIG_HALT;
      bus.command   <= CMD_TRIG_HALT;
      bus.config_in <= '0;
      bus.we        <= '0;
      bus.running   <= 1'b0;
      bus.tx_valid  <= 1'b0;
      bus.tx_data   <= '0;
      trig_q        <= 1'b0;
      fire_pending  <= 1'b0;
      fired_run     <= 1'b0;
      resp_pend     <= 1'b0;
      resp_byte     <= '0;
      tx_is_ack     <= 1'b0;
    end else begin
      trig_q <= bus.trig;

      if (rx_fire)
        byte_cnt <= (byte_cnt == 3'd4) ? 3'd0 : byte_cnt + 3'd1;
      else if (to_expired)
        byte_cnt <= 3'd0;

      // FIRED always wins an idle tx slot; a queued ACK/NAK waits behind it.
      if (!bus.tx_valid) begin
        if (fire_pending) begin
          bus.tx_valid <= 1'b1;
          bus.tx_data  <= FIRED;
          fire_pending <= 1'b0;
          tx_is_ack    <= 1'b0;
        end else if (resp_pend) begin
          bus.tx_valid <= 1'b1;
          bus.tx_data  <= resp_byte;
          resp_pend    <= 1'b0;
          tx_is_ack    <= 1'b1;
        end
      end else if (tx_done) begin
        bus.tx_valid <= 1'b0;
      end

      if (fire_edge) begin
        fire_pending <= 1'b1;
        fired_run    <= 1'b1;
      end

      case (state)
        ST_DECODE: begin
          resp_pend <= 1'b1;
          resp_byte <= ack_byte(opcode);
          if (opcode == CMD_TRIG_RUN) begin
            idle_cmd     <= CMD_TRIG_RUN;
            bus.command  <= CMD_TRIG_RUN;
            bus.running  <= 1'b1;
            fire_pending <= 1'b0;
            fired_run    <= 1'b0;
          end else if (opcode == CMD_TRIG_HALT) begin
            idle_cmd    <= CMD_TRIG_HALT;
            bus.command <= CMD_TRIG_HALT;
            bus.running <= 1'b0;
          end else if (op_is_cfg) begin
            if (bus.running) begin
              resp_byte <= NAK_BUSY;
            end else begin
              // The ACK is queued after the write cycle instead.
              resp_pend     <= 1'b0;
              bus.command   <= opcode;
              bus.config_in <= cfg_buf;
              bus.we        <= mask_buf;
            end
          end else begin
            resp_byte <= NAK_BADOP;
          end
        end
        ST_ISSUE: begin
          bus.command <= idle_cmd;
          bus.we      <= '0;
          resp_pend   <= 1'b1;
          resp_byte   <= ack_byte(opcode);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_trigger_cmd_issuer.sv
// Directed table-driven bench for trigger_cmd_issuer with hand sequences for fire, timeout and reset.
module tb_trigger_cmd_issuer;
  localparam logic [7:0] F1 = 8'hF1;

  logic inclk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  trigger_cmd_issuer_if #(.NSTAGES(4)) bus ();

  trigger_cmd_issuer #(.TIMEOUT(16), .NSTAGES(4)) dut (
    .inclk (inclk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 inclk = ~inclk;

  typedef struct packed {
    logic [7:0]  c;
    logic [23:0] f;
    logic [3:0]  w;
  } wr_t;

  typedef struct {
    logic [39:0] pkt;
    bit          issue;
    logic [7:0]  cmd;
    logic [23:0] cfg;
    logic [3:0]  we;
    logic [7:0]  tx;
    bit          run;
  } vec_t;

  logic [7:0] txq[$];
  wr_t        wlog[$];
  bit         stall_prev = 1'b0;
  logic [7:0] stall_data = '0;
  vec_t       tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Passive monitor: tx handshakes, bus writes, stream stability, RUN level hold
  always @(negedge inclk) begin
    if (rst_n) begin
      if (bus.tx_valid && bus.tx_ready) txq.push_back(bus.tx_data);
      if (stall_prev) begin
        chk("tx_stable_valid", 32'(bus.tx_valid), 32'd1);
        chk("tx_stable_data", 32'(bus.tx_data), 32'(stall_data));
      end
      stall_prev = bus.tx_valid && !bus.tx_ready;
      stall_data = bus.tx_data;
      if (bus.we != 4'd0 || bus.command > 8'd1)
        wlog.push_back('{c: bus.command, f: bus.config_in, w: bus.we});
      if (bus.running) chk("run_cmd_hold", 32'(bus.command), 32'd0);
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge inclk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    forever begin
      @(negedge inclk);
      if (bus.rx_ready) break;
      n++;
      if (n > 200) begin
        $display("FAIL rx_ready_timeout: got 0 expected 1 at %0t", $time);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "rx stalled");
      end
    end
    @(posedge inclk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [39:0] p);
    for (int i = 4; i >= 0; i--) send_byte(p[i*8 +: 8]);
  endtask

  task automatic wait_tx(input int want);
    int n = 0;
    while (txq.size() < want && n < 200) begin
      tick(1);
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit old_run;
    wlog.delete();
    txq.delete();
    old_run = bus.running;
    send_pkt(v.pkt);
    chk("run_not_early", 32'(bus.running), 32'(old_run));
    tick(1);
    chk("run_level", 32'(bus.running), 32'(v.run));
    wait_tx(1);
    tick(3);
    chk("tx_count", txq.size(), 32'd1);
    if (txq.size() > 0) chk("tx_byte", 32'(txq[0]), 32'(v.tx));
    chk("write_count", wlog.size(), v.issue ? 32'd1 : 32'd0);
    if (v.issue && wlog.size() > 0) begin
      chk("wr_command", 32'(wlog[0].c), 32'(v.cmd));
      chk("wr_config", 32'(wlog[0].f), 32'(v.cfg));
      chk("wr_we", 32'(wlog[0].w), 32'(v.we));
      chk("config_hold", 32'(bus.config_in), 32'(v.cfg));
    end
    chk("idle_command", 32'(bus.command), v.run ? 32'd0 : 32'd1);
    chk("idle_we", 32'(bus.we), 32'd0);
  endtask

  task automatic trig_pulse(input int hi, input int lo);
    bus.trig = 1'b1;
    tick(hi);
    bus.trig = 1'b0;
    tick(lo);
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{40'h07_12_34_80_05, 1, 8'h07, 24'h123480, 4'h5, 8'hA7, 0};
    tbl[1] = '{40'h00_00_00_00_00, 0, 8'h00, 24'h0,      4'h0, 8'hA0, 1};
    tbl[2] = '{40'h02_AA_BB_CC_0F, 0, 8'h00, 24'h0,      4'h0, 8'hEB, 1};
    tbl[3] = '{40'h01_00_00_00_00, 0, 8'h00, 24'h0,      4'h0, 8'hA1, 0};
    tbl[4] = '{40'h0C_11_22_33_0F, 0, 8'h00, 24'h0,      4'h0, 8'hEE, 0};
    tbl[5] = '{40'h09_DE_AD_BE_FF, 1, 8'h09, 24'hDEADBE, 4'hF, 8'hA9, 0};
    tbl[6] = '{40'h0A_01_02_03_01, 0, 8'h00, 24'h0,      4'h0, 8'hEE, 0};

    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    bus.trig     = 1'b0;
    tick(3);
    chk("rst_command", 32'(bus.command), 32'd1);
    chk("rst_config", 32'(bus.config_in), 32'd0);
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_running", 32'(bus.running), 32'd0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    @(negedge inclk);
    rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < 3; i++) run_vec(tbl[i]);

    // Two trig edges in one run yield a single FIRED byte
    txq.delete();
    trig_pulse(3, 3);
    trig_pulse(3, 10);
    chk("fire_once", txq.size(), 32'd1);
    if (txq.size() > 0) chk("fire_byte", 32'(txq[0]), 32'(F1));

    for (int i = 3; i < 7; i++) run_vec(tbl[i]);

    // Partial packet dropped by the inter-byte timeout
    send_byte(8'h05);
    send_byte(8'h06);
    send_byte(8'h07);
    tick(20);
    v = '{40'h03_00_FF_00_01, 1, 8'h03, 24'h00FF00, 4'h1, 8'hA3, 0};
    run_vec(v);

    // FIRED held on a stalled stream ahead of a HALT ACK
    run_vec(tbl[1]);
    bus.tx_ready = 1'b0;
    trig_pulse(3, 2);
    chk("stall_fire_valid", 32'(bus.tx_valid), 32'd1);
    chk("stall_fire_data", 32'(bus.tx_data), 32'(F1));
    txq.delete();
    send_pkt(40'h01_00_00_00_00);
    tick(10);
    chk("stall_data_held", 32'(bus.tx_data), 32'(F1));
    chk("stall_halt_cmd", 32'(bus.command), 32'd1);
    chk("stall_halt_run", 32'(bus.running), 32'd0);
    chk("stall_no_tx", txq.size(), 32'd0);
    bus.tx_ready = 1'b1;
    wait_tx(2);
    tick(3);
    chk("release_count", txq.size(), 32'd2);
    if (txq.size() >= 2) begin
      chk("release_first", 32'(txq[0]), 32'(F1));
      chk("release_second", 32'(txq[1]), 32'hA1);
    end

    // Asynchronous reset in the middle of a packet with a byte on the tx stream
    run_vec(tbl[1]);
    bus.tx_ready = 1'b0;
    trig_pulse(3, 1);
    chk("pre_rst_tx_valid", 32'(bus.tx_valid), 32'd1);
    send_byte(8'h07);
    send_byte(8'h12);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_command", 32'(bus.command), 32'd1);
    chk("mid_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("mid_rst_running", 32'(bus.running), 32'd0);
    chk("mid_rst_config", 32'(bus.config_in), 32'd0);
    chk("mid_rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    bus.tx_ready = 1'b1;
    repeat (2) @(negedge inclk);
    rst_n = 1'b1;
    tick(1);
    v = '{40'h04_01_02_03_02, 1, 8'h04, 24'h010203, 4'h2, 8'hA4, 0};
    run_vec(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
